// File: rtl/death_pkg.sv
// Shared types and constants for the death sequencer.
package death_pkg;

  typedef enum logic [2:0] {
    PLAY,
    CONFIRM,
    DYING,
    GAME_OVER,
    RESPAWN
  } death_state_t;

  localparam logic [1:0] WHO_BOY  = 2'b01;
  localparam logic [1:0] WHO_GIRL = 2'b10;
  localparam logic [1:0] WHO_BOTH = 2'b11;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/death_sequencer_rise_edge.sv
// Rising-edge detector for a level input; a level held through reset gives no pulse.
module rise_edge (
  input  logic Clk,
  input  logic Reset,
  input  logic in,
  output logic pulse
);

  logic in_q;

  always_ff @(posedge Clk) begin
    if (Reset) in_q <= 1'b1;
    else       in_q <= in;
  end

  assign pulse = in & ~in_q;

endmodule

// File: rtl/death_sequencer.sv
// Confirms hazard hits over frames, runs the death animation, holds game over
// until a fresh restart press, then pulses respawn.
module death_sequencer
  import death_pkg::*;
#(
  parameter int unsigned DEBOUNCE_FRAMES = 2,
  parameter int unsigned ANIM_FRAMES     = 8,
  parameter int unsigned ANIM_DIV        = 4,
  parameter int unsigned GO_MIN_FRAMES   = 30
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic       level_start,
  input  logic       is_dead_boy,
  input  logic       is_dead_girl,
  input  logic       restart_key,
  output logic       freeze_players,
  output logic [3:0] death_anim_frame,
  output logic       anim_active,
  output logic       show_game_over,
  output logic [1:0] who_died,
  output logic       respawn,
  output logic [7:0] death_count
);

  localparam logic [3:0] DEB_N    = 4'(DEBOUNCE_FRAMES);
  localparam logic [3:0] DIV_LAST = 4'(ANIM_DIV - 1);
  localparam logic [3:0] FRM_LAST = 4'(ANIM_FRAMES - 1);
  localparam logic [7:0] GO_N     = 8'(GO_MIN_FRAMES);

  death_state_t state_q, state_d;
  logic [3:0]   deb_q, deb_d;
  logic [3:0]   div_q, div_d;
  logic [3:0]   frame_q, frame_d;
  logic [7:0]   go_q, go_d;
  logic [1:0]   seen_q, seen_d;
  logic [1:0]   who_q, who_d;
  logic [7:0]   cnt_q, cnt_d;

  logic [1:0] flags;
  logic       hazard;
  logic [3:0] deb_inc;
  logic       key_rise;
  logic       enter_dying;

  assign flags   = ({2{is_dead_boy}} & WHO_BOY) | ({2{is_dead_girl}} & WHO_GIRL);
  assign hazard  = |flags;
  assign deb_inc = deb_q + 4'd1;

  rise_edge u_key_edge (
    .Clk   (Clk),
    .Reset (Reset),
    .in    (restart_key),
    .pulse (key_rise)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= PLAY;
      deb_q   <= '0;
      div_q   <= '0;
      frame_q <= '0;
      go_q    <= '0;
      seen_q  <= '0;
      who_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      deb_q   <= deb_d;
      div_q   <= div_d;
      frame_q <= frame_d;
      go_q    <= go_d;
      seen_q  <= seen_d;
      who_q   <= who_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    deb_d       = deb_q;
    div_d       = div_q;
    frame_d     = frame_q;
    go_d        = go_q;
    seen_d      = seen_q;
    who_d       = who_q;
    cnt_d       = cnt_q;
    enter_dying = 1'b0;

    if (level_start) begin
      state_d = PLAY;
      deb_d   = '0;
      div_d   = '0;
      frame_d = '0;
      go_d    = '0;
      seen_d  = '0;
      who_d   = '0;
    end else begin
      unique case (state_q)
        PLAY: begin
          if (frame_tick && hazard) begin
            deb_d  = 4'd1;
            seen_d = flags;
            if (DEB_N == 4'd1) enter_dying = 1'b1;
            else               state_d     = CONFIRM;
          end
        end
        CONFIRM: begin
          // Any hazard tick keeps the confirmation going; flags accumulate into seen.
          if (frame_tick) begin
            if (hazard) begin
              deb_d  = deb_inc;
              seen_d = seen_q | flags;
              if (deb_inc == DEB_N) enter_dying = 1'b1;
            end else begin
              state_d = PLAY;
              deb_d   = '0;
              seen_d  = '0;
            end
          end
        end
        DYING: begin
          if (frame_tick) begin
            if (div_q == DIV_LAST) begin
              div_d = '0;
              if (frame_q == FRM_LAST) begin
                state_d = GAME_OVER;
                frame_d = '0;
                go_d    = '0;
              end else begin
                frame_d = frame_q + 4'd1;
              end
            end else begin
              div_d = div_q + 4'd1;
            end
          end
        end
        GAME_OVER: begin
          if (frame_tick && (go_q != GO_N)) go_d = go_q + 8'd1;
          if (key_rise && (go_q == GO_N)) state_d = RESPAWN;
        end
        RESPAWN: begin
          state_d = PLAY;
          deb_d   = '0;
          div_d   = '0;
          frame_d = '0;
          go_d    = '0;
          seen_d  = '0;
          who_d   = '0;
        end
        default: state_d = PLAY;
      endcase

      if (enter_dying) begin
        state_d = DYING;
        who_d   = seen_d;
        cnt_d   = sat_inc8(cnt_q);
        div_d   = '0;
        frame_d = '0;
      end
    end
  end

  assign freeze_players   = (state_q == DYING) || (state_q == GAME_OVER) || (state_q == RESPAWN);
  assign anim_active      = (state_q == DYING);
  assign show_game_over   = (state_q == GAME_OVER);
  assign respawn          = (state_q == RESPAWN);
  assign death_anim_frame = frame_q;
  assign who_died         = who_q;
  assign death_count      = cnt_q;

endmodule

// File: tb/tb_death_sequencer.sv
// Scoreboard bench for death_sequencer: directed scenarios plus randomized play.
module tb_death_sequencer;

  localparam int DEB   = 2;
  localparam int NFR   = 8;
  localparam int DIV   = 4;
  localparam int GOMIN = 30;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic       level_start = 1'b0;
  logic       is_dead_boy = 1'b0;
  logic       is_dead_girl = 1'b0;
  logic       restart_key = 1'b0;
  logic       freeze_players;
  logic [3:0] death_anim_frame;
  logic       anim_active;
  logic       show_game_over;
  logic [1:0] who_died;
  logic       respawn;
  logic [7:0] death_count;

  death_sequencer #(
    .DEBOUNCE_FRAMES (DEB),
    .ANIM_FRAMES     (NFR),
    .ANIM_DIV        (DIV),
    .GO_MIN_FRAMES   (GOMIN)
  ) dut (
    .Clk              (Clk),
    .Reset            (Reset),
    .frame_tick       (frame_tick),
    .level_start      (level_start),
    .is_dead_boy      (is_dead_boy),
    .is_dead_girl     (is_dead_girl),
    .restart_key      (restart_key),
    .freeze_players   (freeze_players),
    .death_anim_frame (death_anim_frame),
    .anim_active      (anim_active),
    .show_game_over   (show_game_over),
    .who_died         (who_died),
    .respawn          (respawn),
    .death_count      (death_count)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic       freeze;
    logic       anim;
    logic       go;
    logic       resp;
    logic [3:0] frame;
    bit         chk_frame;
    logic [1:0] who;
    logic [7:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: hazard run length, ticks since death, ticks in game over.
  typedef enum {M_PLAY, M_DYING, M_GO, M_RESP} mode_t;
  mode_t      m_mode = M_PLAY;
  int         m_run = 0;
  int         m_t = 0;
  int         m_go = 0;
  int         m_cnt = 0;
  logic [1:0] m_seen = 2'b00;
  logic [1:0] m_who = 2'b00;
  bit         m_prev_key = 1'b1;

  bit         k = 1'b0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
    end
  endtask

  task automatic model_step(input bit rst, input bit ls, input bit tk,
                            input bit b, input bit g, input bit key);
    bit         rise;
    logic [1:0] fl;
    exp_t       e;
    rise = key && !m_prev_key;
    fl   = {g, b};
    if (rst) begin
      m_mode = M_PLAY; m_run = 0; m_seen = 0; m_who = 0;
      m_cnt = 0; m_t = 0; m_go = 0; m_prev_key = 1'b1;
    end else begin
      m_prev_key = key;
      if (ls) begin
        m_mode = M_PLAY; m_run = 0; m_seen = 0; m_who = 0; m_t = 0; m_go = 0;
      end else begin
        case (m_mode)
          M_PLAY: if (tk) begin
            if (fl != 2'b00) begin
              m_run++;
              m_seen |= fl;
              if (m_run == DEB) begin
                m_mode = M_DYING; m_t = 0; m_who = m_seen;
                if (m_cnt < 255) m_cnt++;
              end
            end else begin
              m_run = 0; m_seen = 0;
            end
          end
          M_DYING: if (tk) begin
            m_t++;
            if (m_t == NFR * DIV) begin m_mode = M_GO; m_go = 0; m_t = 0; end
          end
          M_GO: begin
            if (rise && m_go == GOMIN) m_mode = M_RESP;
            else if (tk && m_go < GOMIN) m_go++;
          end
          M_RESP: begin
            m_mode = M_PLAY; m_who = 0; m_run = 0; m_seen = 0;
          end
        endcase
      end
    end
    e.freeze    = (m_mode != M_PLAY);
    e.anim      = (m_mode == M_DYING);
    e.go        = (m_mode == M_GO);
    e.resp      = (m_mode == M_RESP);
    e.frame     = 4'(m_t / DIV);
    e.chk_frame = (m_mode == M_DYING) || rst;
    e.who       = m_who;
    e.cnt       = 8'(m_cnt);
    exp_q.push_back(e);
  endtask

  // One clock of stimulus, applied on the falling edge.
  task automatic cyc(input bit rst, input bit ls, input bit tk,
                     input bit b, input bit g, input bit key);
    Reset = rst; level_start = ls; frame_tick = tk;
    is_dead_boy = b; is_dead_girl = g; restart_key = key;
    model_step(rst, ls, tk, b, g, key);
    @(negedge Clk);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, k);
  endtask

  task automatic tick(input bit b, input bit g);
    cyc(1'b0, 1'b0, 1'b1, b, g, k);
    cyc(1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), k);
  endtask

  task automatic ticks(input int n);
    repeat (n) tick(1'b0, 1'b0);
  endtask

  task automatic rticks(input int n);
    repeat (n) tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge Clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("freeze_players", 8'(freeze_players), 8'(e.freeze));
        chk("anim_active",    8'(anim_active),    8'(e.anim));
        chk("show_game_over", 8'(show_game_over), 8'(e.go));
        chk("respawn",        8'(respawn),        8'(e.resp));
        chk("who_died",       8'(who_died),       8'(e.who));
        chk("death_count",    death_count,        e.cnt);
        if (e.chk_frame) chk("death_anim_frame", 8'(death_anim_frame), 8'(e.frame));
      end
    end
  end

  initial begin : driver
    int         ep_left;
    logic [1:0] ep_fl;
    logic [1:0] fl;
    bit         tk, ls, rst;
    ep_left = 0;
    ep_fl   = 2'b00;
    @(negedge Clk);

    repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);

    // Single-tick girl hazard aborts confirmation.
    tick(1'b0, 1'b1); tick(1'b0, 1'b0); ticks(2);

    // Boy then both: death, full animation with flags ignored, key held into game over.
    tick(1'b1, 1'b0); tick(1'b1, 1'b1);
    rticks(30);
    k = 1'b1;
    rticks(2);
    ticks(40);
    k = 1'b0; idle(1);
    k = 1'b1; idle(3);
    k = 1'b0; ticks(2);

    // Early restart ignored, later one accepted.
    tick(1'b0, 1'b1); tick(1'b0, 1'b1);
    ticks(32);
    ticks(10);
    k = 1'b1; idle(2);
    k = 1'b0; ticks(25);
    k = 1'b1; idle(3);
    k = 1'b0; idle(2);

    // Reset held mid-animation.
    tick(1'b1, 1'b0); tick(1'b1, 1'b0); ticks(5);
    repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(2);

    // Tick coincident with level_start is discarded.
    tick(1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, k);
    tick(1'b1, 1'b0); tick(1'b0, 1'b0);

    // level_start during game over.
    tick(1'b0, 1'b1); tick(1'b1, 1'b0);
    ticks(32); ticks(5);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, k);
    idle(2);

    // Saturate the death counter, then one more full death.
    repeat (256) begin
      tick(1'b1, 1'b0); tick(1'b1, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, k);
    end
    tick(1'b1, 1'b0); tick(1'b0, 1'b1);
    ticks(32); ticks(GOMIN);
    k = 1'b1; idle(2); k = 1'b0; idle(2);

    // Randomized play with monotone hazard episodes.
    for (int i = 0; i < 4000; i++) begin
      tk  = ($urandom_range(0, 2) == 0);
      ls  = ($urandom_range(0, 399) == 0);
      rst = ($urandom_range(0, 1999) == 0);
      if ($urandom_range(0, 19) == 0) k = ~k;
      if (tk) begin
        if (ep_left == 0 && $urandom_range(0, 5) == 0) begin
          ep_fl   = 2'($urandom_range(1, 3));
          ep_left = $urandom_range(1, 4);
        end
        if (ep_left > 0) begin
          if ($urandom_range(0, 3) == 0) ep_fl |= 2'($urandom_range(1, 3));
          fl = ep_fl;
          ep_left--;
        end else begin
          fl = 2'b00;
        end
      end else begin
        fl = 2'($urandom_range(0, 3));
      end
      cyc(rst, ls, tk, fl[0], fl[1], k);
    end

    @(posedge Clk);
    #2;
    chk("scoreboard_drained", 8'(exp_q.size()), 8'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
